// File: rtl/modulo_controle_vedacao.sv
// Corking-station controller: seals one bottle per arrival, writes back the decremented
// cork count and reloads stock from the supply through a request/acknowledge handshake.
module modulo_controle_vedacao #(
  parameter int WIDTH        = 7,
  parameter int MAX_ROLHAS   = 99,
  parameter int LIMITE_BAIXO = 5,
  parameter int RECARGA      = 15,
  parameter int CICLOS_VEDA  = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [WIDTH-1:0] m_rolhas_in,
  input  logic             garrafa_pronta,
  input  logic             ack_rolhas,
  output logic             veda,
  output logic [WIDTH-1:0] m_rolhas_out,
  output logic             m_rolhas_we,
  output logic             pedido_rolhas,
  output logic             garrafa_vedada,
  output logic             alarme_sem_rolha
);

  typedef enum logic [2:0] {
    IDLE,
    SEAL,
    UPDATE,
    WAIT_CLEAR,
    REQ,
    RELOAD_WR
  } state_t;

  localparam int CW = (CICLOS_VEDA > 1) ? $clog2(CICLOS_VEDA) : 1;
  localparam logic [CW-1:0]  SEAL_LAST = CW'(CICLOS_VEDA - 1);
  localparam logic [WIDTH:0] LIM       = (WIDTH+1)'(LIMITE_BAIXO);
  localparam logic [WIDTH:0] REC       = (WIDTH+1)'(RECARGA);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_ROLHAS);

  state_t          state;
  logic [CW-1:0]   seal_cnt;
  logic [WIDTH:0]  count_ext;
  logic [WIDTH:0]  soma;
  logic [WIDTH-1:0] recarga_sat;
  logic            tem_rolha;
  logic            estoque_baixo;

  assign count_ext     = {1'b0, m_rolhas_in};
  assign tem_rolha     = (m_rolhas_in != '0);
  assign estoque_baixo = (count_ext < LIM);

  // Sum kept one bit wider so an overflowing reload still saturates at the ceiling.
  assign soma        = count_ext + REC;
  assign recarga_sat = (soma > {1'b0, MAXV}) ? MAXV : soma[WIDTH-1:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      seal_cnt     <= '0;
      m_rolhas_out <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          seal_cnt <= '0;
          if (garrafa_pronta && tem_rolha) state <= SEAL;
          else if (estoque_baixo)          state <= REQ;
        end
        SEAL: begin
          if (seal_cnt == SEAL_LAST) begin
            seal_cnt     <= '0;
            m_rolhas_out <= m_rolhas_in - WIDTH'(1);
            state        <= UPDATE;
          end else begin
            seal_cnt <= seal_cnt + CW'(1);
          end
        end
        UPDATE:     state <= WAIT_CLEAR;
        WAIT_CLEAR: if (!garrafa_pronta) state <= IDLE;
        REQ: begin
          if (ack_rolhas) begin
            m_rolhas_out <= recarga_sat;
            state        <= RELOAD_WR;
          end
        end
        RELOAD_WR:  state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Levels follow the frozen state; pulses are gated so a paused write is issued later.
  assign veda             = (state == SEAL);
  assign pedido_rolhas    = (state == REQ);
  assign m_rolhas_we      = enable && ((state == UPDATE) || (state == RELOAD_WR));
  assign garrafa_vedada   = enable && (state == UPDATE);
  assign alarme_sem_rolha = ((state == IDLE) || (state == REQ)) && garrafa_pronta && !tem_rolha;

endmodule

// File: tb/tb_modulo_controle_vedacao.sv
// Directed bench for the corking controller: main instance with a modelled cork register,
// plus two threshold-overridden instances exercising reload saturation.
module tb_modulo_controle_vedacao;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       garrafa_pronta;
  logic       ack_rolhas;
  logic [6:0] cnt;
  logic       ld;
  logic [6:0] ld_val;

  logic       veda, we, pedido, vedada, alarme;
  logic [6:0] out;

  logic       ack_sat;
  logic [6:0] in_a, in_b, out_a, out_b;
  logic       veda_a, we_a, pedido_a, vedada_a, alarme_a;
  logic       veda_b, we_b, pedido_b, vedada_b, alarme_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld)      cnt <= ld_val;
    else if (we) cnt <= out;
  end

  modulo_controle_vedacao dut (
    .clk(clk), .clr(clr), .enable(enable), .m_rolhas_in(cnt),
    .garrafa_pronta(garrafa_pronta), .ack_rolhas(ack_rolhas),
    .veda(veda), .m_rolhas_out(out), .m_rolhas_we(we),
    .pedido_rolhas(pedido), .garrafa_vedada(vedada), .alarme_sem_rolha(alarme)
  );

  modulo_controle_vedacao #(.LIMITE_BAIXO(95)) u_sat_a (
    .clk(clk), .clr(clr), .enable(enable), .m_rolhas_in(in_a),
    .garrafa_pronta(1'b0), .ack_rolhas(ack_sat),
    .veda(veda_a), .m_rolhas_out(out_a), .m_rolhas_we(we_a),
    .pedido_rolhas(pedido_a), .garrafa_vedada(vedada_a), .alarme_sem_rolha(alarme_a)
  );

  modulo_controle_vedacao #(.LIMITE_BAIXO(127)) u_sat_b (
    .clk(clk), .clr(clr), .enable(enable), .m_rolhas_in(in_b),
    .garrafa_pronta(1'b0), .ack_rolhas(ack_sat),
    .veda(veda_b), .m_rolhas_out(out_b), .m_rolhas_we(we_b),
    .pedido_rolhas(pedido_b), .garrafa_vedada(vedada_b), .alarme_sem_rolha(alarme_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; enable = 1'b1; garrafa_pronta = 1'b0; ack_rolhas = 1'b0;
    ack_sat = 1'b0; in_a = 7'd90; in_b = 7'd120;
    ld = 1'b1; ld_val = 7'd20;
    step(2);
    chk("rst_veda", veda, 0);
    chk("rst_we", we, 0);
    chk("rst_out", out, 0);
    chk("rst_pedido", pedido, 0);
    chk("rst_vedada", vedada, 0);
    chk("rst_alarme", alarme, 0);
    clr = 1'b0; ld = 1'b0;

    // Reset mid-seal
    garrafa_pronta = 1'b1;
    step(1);
    chk("seal_start", veda, 1);
    step(1);
    clr = 1'b1;
    #1;
    chk("clr_veda_async", veda, 0);
    chk("clr_we", we, 0);
    chk("clr_out", out, 0);
    garrafa_pronta = 1'b0;
    step(1);
    clr = 1'b0;
    step(1);
    chk("clr_idle_veda", veda, 0);
    chk("clr_no_write", cnt, 20);

    // Normal seal
    garrafa_pronta = 1'b1;
    step(1); chk("seal_c1", veda, 1); chk("seal_c1_we", we, 0);
    step(1); chk("seal_c2", veda, 1);
    step(1); chk("seal_c3", veda, 1); chk("seal_c3_we", we, 0);
    step(1);
    chk("upd_veda", veda, 0);
    chk("upd_we", we, 1);
    chk("upd_out", out, 19);
    chk("upd_vedada", vedada, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_no_veda", veda, 0);
      chk("hold_no_we", we, 0);
    end
    chk("seal_cnt19", cnt, 19);
    garrafa_pronta = 1'b0;
    step(1);
    ack_rolhas = 1'b1;
    step(2);
    chk("ack_idle_we", we, 0);
    chk("ack_idle_pedido", pedido, 0);
    ack_rolhas = 1'b0;

    // Reload from low stock
    ld = 1'b1; ld_val = 7'd4;
    step(1);
    ld = 1'b0;
    step(1);
    chk("req_pedido", pedido, 1);
    step(5);
    chk("req_hold", pedido, 1);
    chk("req_no_we", we, 0);
    ack_rolhas = 1'b1;
    step(1);
    chk("rel_we", we, 1);
    chk("rel_out", out, 19);
    chk("rel_pedido", pedido, 0);
    ack_rolhas = 1'b0;
    step(1);
    chk("rel_cnt", cnt, 19);
    chk("rel_idle_pedido", pedido, 0);

    // Empty with bottle waiting
    ld = 1'b1; ld_val = 7'd0;
    step(1);
    ld = 1'b0;
    garrafa_pronta = 1'b1;
    #1;
    chk("empty_alarm_idle", alarme, 1);
    step(1);
    chk("empty_pedido", pedido, 1);
    chk("empty_alarm_req", alarme, 1);
    chk("empty_veda", veda, 0);
    step(2);
    chk("empty_veda_hold", veda, 0);
    ack_rolhas = 1'b1;
    step(1);
    chk("empty_rel_out", out, 15);
    chk("empty_rel_we", we, 1);
    ack_rolhas = 1'b0;
    step(1);
    chk("empty_alarm_clear", alarme, 0);
    chk("empty_cnt15", cnt, 15);
    step(1);
    chk("empty_seal", veda, 1);
    step(3);
    chk("empty_upd_out", out, 14);
    chk("empty_upd_we", we, 1);
    garrafa_pronta = 1'b0;
    step(2);
    chk("empty_cnt14", cnt, 14);

    // Enable freeze during the write cycle
    garrafa_pronta = 1'b1;
    step(4);
    chk("frz_upd_we", we, 1);
    enable = 1'b0;
    #1;
    chk("frz_we_low", we, 0);
    chk("frz_vedada_low", vedada, 0);
    step(2);
    chk("frz_we_hold", we, 0);
    chk("frz_out", out, 13);
    chk("frz_cnt", cnt, 14);
    enable = 1'b1;
    #1;
    chk("frz_resume_we", we, 1);
    chk("frz_resume_out", out, 13);
    step(1);
    chk("frz_single_pulse", we, 0);
    chk("frz_cnt13", cnt, 13);
    garrafa_pronta = 1'b0;
    step(2);

    // Saturation on reload
    chk("sat_a_req", pedido_a, 1);
    chk("sat_b_req", pedido_b, 1);
    ack_sat = 1'b1;
    step(1);
    chk("sat_a_we", we_a, 1);
    chk("sat_a_out", out_a, 99);
    chk("sat_b_we", we_b, 1);
    chk("sat_b_out", out_b, 99);
    chk("sat_quiet", {veda_a, vedada_a, alarme_a, veda_b, vedada_b, alarme_b}, 0);
    ack_sat = 1'b0;
    step(1);
    chk("sat_a_idle", {we_a, pedido_a}, 0);
    chk("sat_b_idle", {we_b, pedido_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
